// File: rtl/mips_pkg.sv
// Shared MINI-MIPS constants: default bus widths, the canonical NOP and the opcode field layout
// that decode also uses.
package mips_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 15;

   localparam logic [DEF_DATA_W-1:0] NOP = 32'h0000_0000;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_JAL   = 6'h03,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2b
   } opcode_e;

   function automatic opcode_e opcode_of(input logic [DEF_DATA_W-1:0] word);
      return opcode_e'(word[OPCODE_MSB:OPCODE_LSB]);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instr, pc} words between the memory read stage and decode.
// Flush empties it in one edge and wins over push and pop.
module fetch_fifo #(
   parameter  int WIDTH = 47,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] store_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      do_pop   = pop_i && !flush_i && (count_q != '0);
      do_push  = push_i && !flush_i && ((count_q != FULL) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: entry storage is left unreset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (do_push) store_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = store_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_mem.sv
// Instruction store with runtime load port, registered read, self-advancing fetch PC and a
// credit-controlled prefetch FIFO presenting {instr, instr_pc} to decode.
module instr_prefetch_mem
   import mips_pkg::*;
#(
   parameter  int                DATA_W     = DEF_DATA_W,
   parameter  int                ADDR_W     = DEF_ADDR_W,
   parameter  int                DEPTH      = 32,
   parameter  int                FIFO_DEPTH = 4,
   parameter  logic [ADDR_W-1:0] RESET_PC   = '0,
   localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [CNT_W-1:0]  fifo_count
);

   localparam int                IDX_W     = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   MEM_WORDS = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0]  CREDITS   = CNT_W'(FIFO_DEPTH);

   logic [DATA_W-1:0]        mem [DEPTH];
   logic [ADDR_W-1:0]        pc_q, pc_d;
   logic                     inflight_q, inflight_d;
   logic [DATA_W-1:0]        rd_data_q;
   logic [ADDR_W-1:0]        rd_pc_q;
   logic                     issue, push, pop;
   logic                     rd_in_range, ld_in_range;
   logic [CNT_W-1:0]         count;
   logic [DATA_W+ADDR_W-1:0] head;

   assign rd_in_range = {1'b0, pc_q} < MEM_WORDS;
   assign ld_in_range = {1'b0, load_addr} < MEM_WORDS;

   // The in-flight word counts against FIFO space, so a push never finds the FIFO full.
   assign issue = fetch_en && !redirect_valid && ((count + CNT_W'(inflight_q)) < CREDITS);
   assign push  = inflight_q && !redirect_valid;
   assign pop   = instr_valid && instr_ready && !redirect_valid;

   always_comb begin
      pc_d       = pc_q;
      inflight_d = issue;
      if (redirect_valid) pc_d = redirect_pc;
      else if (issue)     pc_d = pc_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
      end
   end

   // Program memory survives reset; a read racing a load of the same word sees the old value.
   always_ff @(posedge clk) begin
      if (load_en && ld_in_range) mem[load_addr[IDX_W-1:0]] <= load_data;
      if (issue) begin
         rd_data_q <= rd_in_range ? mem[pc_q[IDX_W-1:0]] : DATA_W'(NOP);
         rd_pc_q   <= pc_q;
      end
   end

   fetch_fifo #(
      .WIDTH (DATA_W + ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .data_i  ({rd_data_q, rd_pc_q}),
      .head_o  (head),
      .count_o (count)
   );

   assign instr_valid = (count != '0);
   assign instr       = instr_valid ? head[DATA_W+ADDR_W-1:ADDR_W] : '0;
   assign instr_pc    = instr_valid ? head[ADDR_W-1:0] : '0;
   assign fifo_count  = count;

endmodule
